// File: rtl/dmrs_hop_sched_if.sv
// Bundle of request, gold-generator and sequence-generator signals for the
// DMRS hopping scheduler. The slave side is the scheduler itself.
interface dmrs_hop_sched_if;
  // slot request
  logic        start;
  logic [3:0]  n_slot;
  logic [9:0]  n_id;
  logic [1:0]  hop_mode;
  logic [13:0] dmrs_sym_map;
  // gold sequence generator
  logic        gold_rdy;
  logic        gold_bit;
  logic        gold_load;
  logic [30:0] gold_cinit;
  logic        gold_adv;
  // DMRS sequence generator
  logic [7:0]  cap_bits;
  logic        cap_valid;
  logic        seq_start;
  logic        seq_done;
  // status
  logic [3:0]  sym_idx;
  logic        busy;
  logic        done;

  modport slave (
    input  start, n_slot, n_id, hop_mode, dmrs_sym_map, gold_rdy, gold_bit, seq_done,
    output gold_load, gold_cinit, gold_adv, cap_bits, cap_valid, seq_start, sym_idx, busy, done
  );

  modport master (
    output start, n_slot, n_id, hop_mode, dmrs_sym_map, gold_rdy, gold_bit, seq_done,
    input  gold_load, gold_cinit, gold_adv, cap_bits, cap_valid, seq_start, sym_idx, busy, done
  );
endinterface

// File: rtl/dmrs_hop_sched.sv
// Per-slot DMRS group/sequence hopping scheduler: loads the gold generator
// once, walks its stream forward to each DMRS symbol's hopping bits, captures
// them and hands them to the DMRS sequence generator one symbol at a time.
module dmrs_hop_sched #(
  parameter int N_SYMB_SLOT = 14,
  parameter int CNT_W       = 11,
  parameter int CINIT_W     = 31
) (
  input logic          clk,
  input logic          reset,
  dmrs_hop_sched_if.slave hs
);

  typedef enum logic [3:0] {
    IDLE, LOAD, WARM, SEEK, CAPT, ISSUE, WAIT, NEXT, DONE
  } state_t;

  state_t                 state_q;
  logic [3:0]             n_slot_q;
  logic [1:0]             mode_q;
  logic [N_SYMB_SLOT-1:0] map_q;
  logic [3:0]             l_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [2:0]             k_q;
  logic                   warm_first_q;
  logic                   gold_load_q;
  logic [CINIT_W-1:0]     gold_cinit_q;
  logic [7:0]             cap_bits_q;
  logic                   cap_valid_q;
  logic                   seq_start_q;
  logic [3:0]             sym_idx_q;
  logic                   busy_q;
  logic                   done_q;

  logic [3:0]             first_l;
  logic                   first_found;
  logic [3:0]             next_l;
  logic                   next_found;
  logic [9:0]             nid_div30;
  logic [CINIT_W-1:0]     cinit_sel;
  logic [1:0]             mode_in;
  logic [CNT_W-1:0]       sym_lin;
  logic [CNT_W-1:0]       base;
  logic                   seek_step;
  logic                   cap_last;

  // Mode 3 behaves exactly like "no hopping".
  assign mode_in   = (hs.hop_mode == 2'd3) ? 2'd0 : hs.hop_mode;
  assign nid_div30 = hs.n_id / 10'd30;

  // Group hopping seeds with floor(n_id/30), sequence hopping with n_id itself.
  always_comb begin
    cinit_sel = '0;
    if (mode_in == 2'd1)      cinit_sel = CINIT_W'(nid_div30);
    else if (mode_in == 2'd2) cinit_sel = CINIT_W'(hs.n_id);
  end

  // Priority search: lowest set bit of the incoming map, and lowest latched bit above l.
  always_comb begin
    first_l     = '0;
    first_found = 1'b0;
    next_l      = '0;
    next_found  = 1'b0;
    for (int i = N_SYMB_SLOT - 1; i >= 0; i--) begin
      if (hs.dmrs_sym_map[i]) begin
        first_l     = 4'(i);
        first_found = 1'b1;
      end
      if (map_q[i] && (4'(i) > l_q)) begin
        next_l     = 4'(i);
        next_found = 1'b1;
      end
    end
  end

  // Gold bit index of the first hopping bit for symbol l: 8 bits per symbol in
  // group hopping, one bit per symbol in sequence hopping.
  assign sym_lin   = CNT_W'(N_SYMB_SLOT) * CNT_W'(n_slot_q) + CNT_W'(l_q);
  assign base      = (mode_q == 2'd1) ? {sym_lin[CNT_W-4:0], 3'b000} : sym_lin;
  assign seek_step = (state_q == SEEK) && (bit_cnt_q < base) && hs.gold_rdy;
  assign cap_last  = (mode_q == 2'd1) ? (k_q == 3'd7) : 1'b1;

  // The advance strobe must follow gold_rdy in the same cycle, so it is decoded, not registered.
  assign hs.gold_adv   = seek_step || ((state_q == CAPT) && hs.gold_rdy);
  assign hs.gold_load  = gold_load_q;
  assign hs.gold_cinit = gold_cinit_q;
  assign hs.cap_bits   = cap_bits_q;
  assign hs.cap_valid  = cap_valid_q;
  assign hs.seq_start  = seq_start_q;
  assign hs.sym_idx    = sym_idx_q;
  assign hs.busy       = busy_q;
  assign hs.done       = done_q;

  // Slot FSM; strobes are set on the transition into the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      n_slot_q     <= '0;
      mode_q       <= '0;
      map_q        <= '0;
      l_q          <= '0;
      bit_cnt_q    <= '0;
      k_q          <= '0;
      warm_first_q <= 1'b0;
      gold_load_q  <= 1'b0;
      gold_cinit_q <= '0;
      cap_bits_q   <= '0;
      cap_valid_q  <= 1'b0;
      seq_start_q  <= 1'b0;
      sym_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      gold_load_q <= 1'b0;
      cap_valid_q <= 1'b0;
      seq_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs.start) begin
            n_slot_q     <= hs.n_slot;
            map_q        <= hs.dmrs_sym_map;
            mode_q       <= mode_in;
            l_q          <= first_l;
            gold_cinit_q <= cinit_sel;
            busy_q       <= 1'b1;
            if (!first_found) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (mode_in == 2'd0) begin
              state_q     <= ISSUE;
              cap_valid_q <= 1'b1;
              seq_start_q <= 1'b1;
              sym_idx_q   <= first_l;
              cap_bits_q  <= '0;
            end else begin
              state_q     <= LOAD;
              gold_load_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          bit_cnt_q    <= '0;
          warm_first_q <= 1'b1;
          state_q      <= WARM;
        end
        WARM: begin
          // gold_rdy may still reflect the previous seed in the first cycle
          warm_first_q <= 1'b0;
          if (!warm_first_q && hs.gold_rdy) state_q <= SEEK;
        end
        SEEK: begin
          if (bit_cnt_q == base) begin
            state_q <= CAPT;
            k_q     <= '0;
          end else if (seek_step) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        CAPT: begin
          if (hs.gold_rdy) begin
            if (mode_q == 2'd2) cap_bits_q <= {7'b0, hs.gold_bit};
            else                cap_bits_q[k_q] <= hs.gold_bit;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            k_q       <= k_q + 3'd1;
            if (cap_last) begin
              state_q     <= ISSUE;
              cap_valid_q <= 1'b1;
              seq_start_q <= 1'b1;
              sym_idx_q   <= l_q;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (hs.seq_done) state_q <= NEXT;
        end
        NEXT: begin
          if (!next_found) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            l_q <= next_l;
            if (mode_q == 2'd0) begin
              state_q     <= ISSUE;
              cap_valid_q <= 1'b1;
              seq_start_q <= 1'b1;
              sym_idx_q   <= next_l;
              cap_bits_q  <= '0;
            end else begin
              state_q <= SEEK;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmrs_hop_sched.sv
// Bench for dmrs_hop_sched: emulates the gold and DMRS sequence generators,
// predicts each slot's seq_start pulses from the hopping rules and checks the
// scheduler every cycle, plus hand-computed literals per directed case.
module tb_dmrs_hop_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmrs_hop_sched_if bus ();
  dmrs_hop_sched dut (.clk(clk), .reset(reset), .hs(bus));

  int n_pass = 0, n_checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected per-slot behaviour
  int         exp_sym[$];
  logic [7:0] exp_cap[$];
  int         exp_cinit, exp_adv, exp_loads;
  // observations
  int         got_sym[$];
  logic [7:0] got_cap[$];
  int n_adv, n_load, n_ss, n_done, last_cinit, last_adv_cyc, ss_cyc, done_cyc, start_cyc;
  // generator emulation
  int g_pos = 0, g_warm = 0, g_stall = 0, g_ci = 0;
  bit g_loaded = 0, g_stalled = 0;
  int stall_pos = -1, seq_delay = 1, seq_wait = 0;
  bit spur = 0, seq_pend = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference gold stream: a fixed scrambled bit per (seed, index).
  function automatic bit cbit(input int ci, input int i);
    logic [31:0] x;
    x = (32'(i) ^ (32'(ci) << 11)) * 32'h9E3779B1;
    return x[29];
  endfunction

  // What the slot must produce, derived straight from the hopping rules.
  task automatic build_model(input int mode, input int ns, input int nid, input logic [13:0] map);
    int m, base;
    logic [7:0] cb;
    m = (mode == 3) ? 0 : mode;
    exp_sym.delete(); exp_cap.delete(); got_sym.delete(); got_cap.delete();
    exp_cinit = (m == 1) ? nid / 30 : (m == 2) ? nid : 0;
    exp_loads = (m != 0 && map != 0) ? 1 : 0;
    exp_adv = 0;
    for (int l = 0; l < 14; l++) begin
      if (map[l]) begin
        cb = 8'h00;
        if (m == 1) begin
          base = 8 * (14 * ns + l);
          for (int b = 0; b < 8; b++) cb[b] = cbit(exp_cinit, base + b);
          exp_adv = base + 8;
        end else if (m == 2) begin
          base = 14 * ns + l;
          cb[0] = cbit(exp_cinit, base);
          exp_adv = base + 1;
        end
        exp_sym.push_back(l);
        exp_cap.push_back(cb);
      end
    end
    n_adv = 0; n_load = 0; n_ss = 0; n_done = 0; last_cinit = -1;
    last_adv_cyc = -100; ss_cyc = 0; done_cyc = 0;
  endtask

  // Gold and sequence generator responders.
  initial begin
    bit ld, adv, ss;
    bus.gold_rdy = 1'b0; bus.gold_bit = 1'b0; bus.seq_done = 1'b0;
    forever begin
      @(negedge clk);
      ld = bus.gold_load; adv = bus.gold_adv; ss = bus.seq_start;
      if (ld) g_ci = int'(bus.gold_cinit);
      if (ss && spur && !reset) bus.seq_done = 1'b1;  // lands in the ISSUE cycle
      @(posedge clk); #1;
      if (reset) begin
        g_loaded = 0; g_stall = 0; seq_pend = 0; bus.seq_done = 1'b0;
      end else begin
        if (ld) begin g_loaded = 1; g_pos = 0; g_warm = 3; g_stalled = 0; end
        else if (adv) g_pos++;
        if (g_warm > 0) g_warm--;
        if (g_stall > 0) g_stall--;
        else if (!g_stalled && stall_pos >= 0 && g_loaded && g_warm == 0 && g_pos == stall_pos) begin
          g_stall = 5; g_stalled = 1;
        end
        bus.seq_done = 1'b0;
        if (ss) begin seq_pend = 1; seq_wait = seq_delay; end
        else if (seq_pend) begin
          if (seq_wait == 0) begin bus.seq_done = 1'b1; seq_pend = 0; end
          else seq_wait--;
        end
      end
      bus.gold_rdy = g_loaded && g_warm == 0 && g_stall == 0;
      bus.gold_bit = bus.gold_rdy ? cbit(g_ci, g_pos) : ~cbit(g_ci, g_pos);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check((bus.cap_valid == bus.seq_start) && !(bus.gold_adv && !bus.gold_rdy) &&
            !(bus.gold_adv && seq_pend) && !(bus.seq_start && seq_pend) && !(bus.gold_load && bus.gold_adv),
            "cycle_rules", {bus.cap_valid, bus.seq_start, bus.gold_adv, bus.gold_rdy, bus.gold_load, seq_pend},
            {bus.seq_start, bus.seq_start, 4'b0});
      if (bus.gold_load) begin
        n_load++; last_cinit = int'(bus.gold_cinit);
        check(int'(bus.gold_cinit) == exp_cinit, "gold_cinit", bus.gold_cinit, exp_cinit);
      end
      if (bus.gold_adv) begin n_adv++; last_adv_cyc = cyc; end
      if (bus.seq_start) begin
        n_ss++; ss_cyc = cyc;
        got_sym.push_back(int'(bus.sym_idx)); got_cap.push_back(bus.cap_bits);
        if (exp_sym.size() == 0) check(1'b0, "extra_seq_start", bus.sym_idx, 0);
        else begin
          check(int'(bus.sym_idx) == exp_sym[0], "sym_idx", bus.sym_idx, exp_sym[0]);
          check(bus.cap_bits == exp_cap[0], "cap_bits", bus.cap_bits, exp_cap[0]);
          void'(exp_sym.pop_front()); void'(exp_cap.pop_front());
        end
      end
      if (bus.done) begin
        n_done++; done_cyc = cyc;
        check(exp_sym.size() == 0, "done_before_all_symbols", exp_sym.size(), 0);
      end
    end
  end

  task automatic check_zero(input string name);
    check({bus.gold_load, bus.gold_adv, bus.cap_valid, bus.seq_start, bus.busy, bus.done,
           bus.cap_bits, bus.sym_idx} == 18'd0 && bus.gold_cinit == 31'd0, name,
          {bus.gold_load, bus.gold_adv, bus.cap_valid, bus.seq_start, bus.busy, bus.done,
           bus.cap_bits, bus.sym_idx}, 0);
  endtask

  task automatic drive_start(input int mode, input int ns, input int nid, input logic [13:0] map);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.hop_mode = 2'(mode); bus.n_slot = 4'(ns);
    bus.n_id = 10'(nid); bus.dmrs_sym_map = map;
    start_cyc = cyc;
    @(posedge clk); #1;
    // scramble the request inputs so only latched values can be used
    bus.start = 1'b0; bus.hop_mode = 2'd1; bus.n_slot = 4'hF; bus.n_id = 10'h3FF; bus.dmrs_sym_map = 14'h3FFF;
  endtask

  task automatic run_slot(input string tag, input int mode, input int ns, input int nid,
                          input logic [13:0] map, input int delay, input bit sp,
                          input int stpos, input bit start_in_wait);
    build_model(mode, ns, nid, map);
    seq_delay = delay; spur = sp; stall_pos = stpos;
    drive_start(mode, ns, nid, map);
    if (start_in_wait) begin
      for (int t = 0; t < 3000 && !seq_pend; t++) @(posedge clk);
      #2;
      bus.start = 1'b1; bus.hop_mode = 2'd0; bus.dmrs_sym_map = 14'h0001;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int t = 0; t < 4000 && n_done == 0; t++) @(posedge clk);
    check(n_done == 1, {tag, "_done_seen"}, n_done, 1);
    check(exp_sym.size() == 0, {tag, "_symbols_left"}, exp_sym.size(), 0);
    check(n_adv == exp_adv, {tag, "_adv_total"}, n_adv, exp_adv);
    check(n_load == exp_loads, {tag, "_load_count"}, n_load, exp_loads);
    repeat (3) @(posedge clk);
    #1;
    check(bus.busy == 1'b0 && n_done == 1, {tag, "_idle_after"}, {bus.busy, 8'(n_done)}, 1);
    spur = 0; stall_pos = -1;
  endtask

  initial begin
    bus.start = 1'b0; bus.n_slot = '0; bus.n_id = '0; bus.hop_mode = '0; bus.dmrs_sym_map = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;

    // abort in the middle of capturing group-hopping bits
    build_model(1, 0, 65, 14'h0004);
    drive_start(1, 0, 65, 14'h0004);
    for (int t = 0; t < 500 && n_adv < 18; t++) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("abort_immediate");
    @(negedge clk);
    check_zero("abort_next_cycle");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    check(n_done == 0, "abort_no_done", n_done, 0);

    // group hopping, n_id 65 -> seed 2, symbol 2 -> bits c(16..23)
    run_slot("m1", 1, 0, 65, 14'h0004, 1, 0, -1, 0);
    check(last_cinit == 2, "m1_cinit_lit", last_cinit, 2);
    check(n_adv == 24, "m1_adv_lit", n_adv, 24);
    check(ss_cyc - last_adv_cyc == 1, "m1_capvalid_latency", ss_cyc - last_adv_cyc, 1);

    // no hopping, symbols 0 and 2
    run_slot("m0", 0, 5, 77, 14'h0005, 3, 0, -1, 0);
    check(got_sym.size() == 2 && got_sym[0] == 0 && got_sym[1] == 2, "m0_syms_lit",
          {got_sym.size() > 0 ? 8'(got_sym[0]) : 8'hFF, got_sym.size() > 1 ? 8'(got_sym[1]) : 8'hFF}, 16'h0002);
    check(got_cap.size() == 2 && got_cap[0] == 8'h00 && got_cap[1] == 8'h00, "m0_cap_lit", got_cap.size(), 2);
    check(n_load == 0, "m0_no_load_lit", n_load, 0);

    // sequence hopping, n_id 300, slot 1, symbols 2 and 11 -> c(16), c(25)
    run_slot("m2", 2, 1, 300, 14'h0804, 2, 0, -1, 0);
    check(last_cinit == 300, "m2_cinit_lit", last_cinit, 300);
    check(n_adv == 26, "m2_adv_lit", n_adv, 26);
    check(got_sym.size() == 2 && got_sym[1] == 11, "m2_syms_lit", got_sym.size(), 2);

    // gold_rdy stall in SEEK, spurious done in ISSUE, late done, start while waiting
    run_slot("stall", 1, 3, 1000, 14'h0060, 20, 1, 10, 1);
    check(n_ss == 2, "stall_seq_starts", n_ss, 2);

    // empty map: done one cycle after start, nothing else
    run_slot("empty", 1, 2, 500, 14'h0000, 1, 0, -1, 0);
    check(done_cyc - start_cyc == 1, "empty_done_latency", done_cyc - start_cyc, 1);
    check(n_load == 0 && n_ss == 0, "empty_quiet", {8'(n_load), 8'(n_ss)}, 0);

    // mode 3 behaves as no hopping
    run_slot("m3", 3, 7, 900, 14'h2001, 0, 0, -1, 0);
    check(got_sym.size() == 2 && got_sym[1] == 13 && got_cap[1] == 8'h00, "m3_lit", got_sym.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
